pc_redirect_ctrl: RTL and testbench

Sequences every front-end redirect into the PC stage. Sources are commit-time exceptions and execute-time branch mispredictions.
- Arbitrates between the two sources and holds the winning request until fetch can accept it.
- Issues a single-cycle flush carrying the target and delay-slot information, then holds stall for a fixed recovery window.
- Maintains a 1-bit fetch epoch so that mispredictions reported by wrong-path instructions are discarded.

---
 rtl/pc_redirect_ctrl_pkg.sv | 20 ++
 rtl/pc_redirect_ctrl_pending.sv | 56 +++++
 rtl/pc_redirect_ctrl.sv | 102 ++++++++++
 tb/tb_pc_redirect_ctrl.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared encodings for the PC redirect controller: FSM states, request kind
// and the default recovery window.
package pc_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    typedef enum logic {
        KIND_MIS = 1'b0,
        KIND_EXC = 1'b1
    } kind_t;

    localparam int DEFAULT_RECOVER_CYCLES = 2;
    localparam int CNT_WIDTH              = 4;

endpackage

// File: rtl/pc_redirect_ctrl_pending.sv
// Pending redirect register with the exception/misprediction merge rules.
// An exception always overwrites; a misprediction only fills an empty slot,
// only with the current epoch, and never while the FSM is flushing.
module pc_redirect_ctrl_pending
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exc_valid,
    input  logic [ADDR_WIDTH-1:0] exc_target,
    input  logic                  mis_valid,
    input  logic                  mis_epoch,
    input  logic [ADDR_WIDTH-1:0] mis_target,
    input  logic [ADDR_WIDTH-1:0] mis_inst_pc,
    input  logic                  epoch,
    input  logic                  mis_allow,
    input  logic                  clear,
    output logic                  capture,
    output logic                  valid,
    output logic                  is_branch,
    output logic [ADDR_WIDTH-1:0] target,
    output logic [ADDR_WIDTH-1:0] inst_pc
);

    kind_t kind;
    logic  mis_ok;

    // A misprediction is taken only into an empty slot; exception beats it.
    assign mis_ok    = mis_valid && (mis_epoch == epoch) && mis_allow && !valid && !exc_valid;
    assign capture   = exc_valid || mis_ok;
    assign is_branch = (kind == KIND_MIS);

    // Pending slot update: exception overwrite, misprediction fill, or clear after flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid   <= 1'b0;
            kind    <= KIND_EXC;
            target  <= '0;
            inst_pc <= '0;
        end else if (exc_valid) begin
            valid  <= 1'b1;
            kind   <= KIND_EXC;
            target <= exc_target;
        end else if (mis_ok) begin
            valid   <= 1'b1;
            kind    <= KIND_MIS;
            target  <= mis_target;
            inst_pc <= mis_inst_pc;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Front-end redirect sequencer: holds a pending redirect until fetch can
// accept it, pulses flush for one cycle, stalls for a recovery window and
// flips the fetch epoch so wrong-path mispredictions are ignored.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int RECOVER_CYCLES = DEFAULT_RECOVER_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exc_valid,
    input  logic [ADDR_WIDTH-1:0] exc_target,
    input  logic                  mis_valid,
    input  logic                  mis_epoch,
    input  logic [ADDR_WIDTH-1:0] mis_target,
    input  logic [ADDR_WIDTH-1:0] mis_inst_pc,
    input  logic                  fetch_ready,
    input  logic                  stall_req,
    output logic                  flush,
    output logic                  stall,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  redirect_is_branch,
    output logic [ADDR_WIDTH-1:0] redirect_inst_pc,
    output logic                  epoch,
    output logic                  busy
);

    localparam logic [CNT_WIDTH-1:0] RC_INIT =
        (RECOVER_CYCLES > 0) ? CNT_WIDTH'(RECOVER_CYCLES - 1) : '0;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 capture;
    logic                 pend_valid;

    // The redirect outputs are the pending register itself, so they track
    // overwrites during HOLD and keep their last value once the slot clears.
    pc_redirect_ctrl_pending #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pending (
        .clk         (clk),
        .rst         (rst),
        .exc_valid   (exc_valid),
        .exc_target  (exc_target),
        .mis_valid   (mis_valid),
        .mis_epoch   (mis_epoch),
        .mis_target  (mis_target),
        .mis_inst_pc (mis_inst_pc),
        .epoch       (epoch),
        .mis_allow   (state != ST_FLUSH),
        .clear       (state == ST_FLUSH),
        .capture     (capture),
        .valid       (pend_valid),
        .is_branch   (redirect_is_branch),
        .target      (redirect_pc),
        .inst_pc     (redirect_inst_pc)
    );

    assign flush = (state == ST_FLUSH);
    assign busy  = (state != ST_IDLE);
    assign stall = busy || stall_req;

    // Redirect FSM with recovery counter and epoch flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            epoch <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (capture) state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (fetch_ready) state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    epoch <= ~epoch;
                    if (RECOVER_CYCLES > 0) begin
                        state <= ST_RECOVER;
                        cnt   <= RC_INIT;
                    end else if (exc_valid) begin
                        // Only an exception taken this cycle survives the clear.
                        state <= ST_HOLD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RECOVER: begin
                    if (cnt == '0) begin
                        state <= (pend_valid || capture) ? ST_HOLD : ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl with hand-computed expectations.
module tb_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exc_valid = 1'b0;
    logic [31:0] exc_target = '0;
    logic        mis_valid = 1'b0;
    logic        mis_epoch = 1'b0;
    logic [31:0] mis_target = '0;
    logic [31:0] mis_inst_pc = '0;
    logic        fetch_ready = 1'b0;
    logic        stall_req = 1'b0;
    logic        flush;
    logic        stall;
    logic [31:0] redirect_pc;
    logic        redirect_is_branch;
    logic [31:0] redirect_inst_pc;
    logic        epoch;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    pc_redirect_ctrl #(
        .ADDR_WIDTH     (32),
        .RECOVER_CYCLES (2)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .exc_valid          (exc_valid),
        .exc_target         (exc_target),
        .mis_valid          (mis_valid),
        .mis_epoch          (mis_epoch),
        .mis_target         (mis_target),
        .mis_inst_pc        (mis_inst_pc),
        .fetch_ready        (fetch_ready),
        .stall_req          (stall_req),
        .flush              (flush),
        .stall              (stall),
        .redirect_pc        (redirect_pc),
        .redirect_is_branch (redirect_is_branch),
        .redirect_inst_pc   (redirect_inst_pc),
        .epoch              (epoch),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge; inputs driven here are
    // sampled at the following edge, outputs read here are settled.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        exc_valid   = 1'b0;
        mis_valid   = 1'b0;
        mis_epoch   = 1'b0;
        fetch_ready = 1'b0;
        stall_req   = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        cyc();
        n_cmp++;
        if ({flush, stall, busy, epoch, redirect_is_branch} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000", {flush, stall, busy, epoch, redirect_is_branch});
        end
        n_cmp++;
        if ({redirect_pc, redirect_inst_pc} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_addr: got %h want 0", {redirect_pc, redirect_inst_pc});
        end
        rst = 1'b0;
        cyc();
        stall_req = 1'b1;
        #1;
        n_cmp++;
        if ({stall, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL idle_stall_req: {stall,busy} got %b want 10", {stall, busy});
        end
        stall_req = 1'b0;
        cyc();
    endtask

    task automatic test_exc_idle();
        do_reset();
        // cycle 0
        exc_valid   = 1'b1;
        exc_target  = 32'hBFC00380;
        fetch_ready = 1'b1;
        cyc(); // cycle 1
        exc_valid = 1'b0;
        n_cmp++;
        if ({flush, stall, busy} !== 3'b011) begin
            n_fail++;
            $display("FAIL exc_c1_hold: {flush,stall,busy} got %b want 011", {flush, stall, busy});
        end
        cyc(); // cycle 2
        n_cmp++;
        if ({flush, stall, busy, redirect_is_branch, epoch} !== 5'b11100) begin
            n_fail++;
            $display("FAIL exc_c2_flush: {flush,stall,busy,br,epoch} got %b want 11100",
                     {flush, stall, busy, redirect_is_branch, epoch});
        end
        n_cmp++;
        if (redirect_pc !== 32'hBFC00380) begin
            n_fail++;
            $display("FAIL exc_c2_pc: got %h want bfc00380", redirect_pc);
        end
        cyc(); // cycle 3
        n_cmp++;
        if ({flush, stall, epoch} !== 3'b011) begin
            n_fail++;
            $display("FAIL exc_c3_recover: {flush,stall,epoch} got %b want 011", {flush, stall, epoch});
        end
        cyc(); // cycle 4
        n_cmp++;
        if ({flush, stall, busy} !== 3'b011) begin
            n_fail++;
            $display("FAIL exc_c4_recover: {flush,stall,busy} got %b want 011", {flush, stall, busy});
        end
        cyc(); // cycle 5
        n_cmp++;
        if ({flush, stall, busy, epoch} !== 4'b0001) begin
            n_fail++;
            $display("FAIL exc_c5_idle: {flush,stall,busy,epoch} got %b want 0001", {flush, stall, busy, epoch});
        end
        fetch_ready = 1'b0;
    endtask

    task automatic test_mis_hold();
        do_reset();
        mis_valid   = 1'b1;
        mis_epoch   = 1'b0;
        mis_target  = 32'h80001000;
        mis_inst_pc = 32'h80000F00;
        fetch_ready = 1'b0;
        cyc(); // cycle 1, HOLD
        mis_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({flush, stall, busy} !== 3'b011) begin
                n_fail++;
                $display("FAIL mis_hold_%0d: {flush,stall,busy} got %b want 011", i, {flush, stall, busy});
            end
            if (i < 4) cyc();
        end
        n_cmp++;
        if ({redirect_is_branch, redirect_pc, redirect_inst_pc} !== {1'b1, 32'h80001000, 32'h80000F00}) begin
            n_fail++;
            $display("FAIL mis_hold_regs: br=%b pc=%h ipc=%h want 1 80001000 80000f00",
                     redirect_is_branch, redirect_pc, redirect_inst_pc);
        end
        fetch_ready = 1'b1;
        cyc();
        n_cmp++;
        if ({flush, stall, redirect_is_branch} !== 3'b111) begin
            n_fail++;
            $display("FAIL mis_flush: {flush,stall,br} got %b want 111", {flush, stall, redirect_is_branch});
        end
        n_cmp++;
        if (redirect_inst_pc !== 32'h80000F00 || redirect_pc !== 32'h80001000) begin
            n_fail++;
            $display("FAIL mis_flush_addr: pc=%h ipc=%h want 80001000 80000f00", redirect_pc, redirect_inst_pc);
        end
        fetch_ready = 1'b0;
        cyc();
        cyc();
        cyc();
        n_cmp++;
        if ({busy, epoch} !== 2'b01) begin
            n_fail++;
            $display("FAIL mis_done: {busy,epoch} got %b want 01", {busy, epoch});
        end
    endtask

    task automatic test_priority();
        do_reset();
        mis_valid   = 1'b1;
        mis_epoch   = 1'b0;
        mis_target  = 32'h80001000;
        mis_inst_pc = 32'h80000F00;
        cyc(); // cycle 1, HOLD with MIS
        mis_valid  = 1'b0;
        exc_valid  = 1'b1;
        exc_target = 32'hBFC00380;
        cyc(); // cycle 2
        exc_valid   = 1'b0;
        fetch_ready = 1'b1;
        n_cmp++;
        if ({redirect_is_branch, redirect_pc} !== {1'b0, 32'hBFC00380}) begin
            n_fail++;
            $display("FAIL prio_overwrite: br=%b pc=%h want 0 bfc00380", redirect_is_branch, redirect_pc);
        end
        cyc(); // cycle 3, FLUSH
        n_cmp++;
        if ({flush, redirect_is_branch, redirect_pc} !== {2'b10, 32'hBFC00380}) begin
            n_fail++;
            $display("FAIL prio_flush: flush=%b br=%b pc=%h want 1 0 bfc00380", flush, redirect_is_branch, redirect_pc);
        end
        cyc();
        cyc();
        cyc(); // idle, epoch 1
        // same-cycle EXC and MIS
        exc_valid   = 1'b1;
        exc_target  = 32'hBFC00200;
        mis_valid   = 1'b1;
        mis_epoch   = 1'b1;
        mis_target  = 32'h80002000;
        mis_inst_pc = 32'h80001F00;
        cyc(); // HOLD
        exc_valid = 1'b0;
        mis_valid = 1'b0;
        n_cmp++;
        if ({busy, redirect_is_branch, redirect_pc} !== {2'b10, 32'hBFC00200}) begin
            n_fail++;
            $display("FAIL prio_same_cycle: busy=%b br=%b pc=%h want 1 0 bfc00200", busy, redirect_is_branch, redirect_pc);
        end
        n_cmp++;
        if (redirect_inst_pc !== 32'h80000F00) begin
            n_fail++;
            $display("FAIL prio_inst_pc_kept: got %h want 80000f00", redirect_inst_pc);
        end
        cyc(); // FLUSH
        n_cmp++;
        if ({flush, redirect_pc} !== {1'b1, 32'hBFC00200}) begin
            n_fail++;
            $display("FAIL prio_same_flush: flush=%b pc=%h want 1 bfc00200", flush, redirect_pc);
        end
        cyc();
        cyc();
        cyc();
        n_cmp++;
        if ({busy, epoch} !== 2'b00) begin
            n_fail++;
            $display("FAIL prio_done: {busy,epoch} got %b want 00", {busy, epoch});
        end
        fetch_ready = 1'b0;
    endtask

    task automatic test_stale_epoch();
        do_reset();
        exc_valid   = 1'b1;
        exc_target  = 32'hBFC00380;
        fetch_ready = 1'b1;
        cyc(); // cycle 1
        exc_valid = 1'b0;
        cyc(); // cycle 2, FLUSH: MIS with the old epoch
        mis_valid   = 1'b1;
        mis_epoch   = 1'b0;
        mis_target  = 32'h80004000;
        mis_inst_pc = 32'h80003F00;
        cyc(); // cycle 3, RECOVER, epoch 1
        n_cmp++;
        if (epoch !== 1'b1) begin
            n_fail++;
            $display("FAIL stale_epoch_flip: got %b want 1", epoch);
        end
        cyc(); // cycle 4
        cyc(); // cycle 5, IDLE, stale MIS still driven
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({busy, flush} !== 2'b00) begin
                n_fail++;
                $display("FAIL stale_ignored_%0d: {busy,flush} got %b want 00", i, {busy, flush});
            end
            cyc();
        end
        mis_valid = 1'b0;
        // second exception; a new-epoch MIS in RECOVER is queued
        exc_valid = 1'b1;
        cyc(); // cycle 1
        exc_valid = 1'b0;
        cyc(); // cycle 2 FLUSH
        cyc(); // cycle 3 RECOVER, epoch 0
        mis_valid   = 1'b1;
        mis_epoch   = 1'b0;
        mis_target  = 32'h80003000;
        mis_inst_pc = 32'h80002F00;
        cyc(); // cycle 4
        mis_valid = 1'b0;
        cyc(); // cycle 5 HOLD
        n_cmp++;
        if ({busy, flush, redirect_is_branch} !== 3'b101) begin
            n_fail++;
            $display("FAIL recover_mis_hold: {busy,flush,br} got %b want 101", {busy, flush, redirect_is_branch});
        end
        cyc(); // cycle 6 FLUSH
        n_cmp++;
        if ({flush, redirect_pc, redirect_inst_pc} !== {1'b1, 32'h80003000, 32'h80002F00}) begin
            n_fail++;
            $display("FAIL recover_mis_flush: flush=%b pc=%h ipc=%h want 1 80003000 80002f00",
                     flush, redirect_pc, redirect_inst_pc);
        end
        fetch_ready = 1'b0;
        cyc();
        cyc();
        cyc();
    endtask

    task automatic test_exc_recover();
        do_reset();
        exc_valid   = 1'b1;
        exc_target  = 32'hBFC00380;
        fetch_ready = 1'b1;
        cyc(); // cycle 1
        exc_valid = 1'b0;
        cyc(); // cycle 2 FLUSH
        cyc(); // cycle 3 RECOVER
        exc_valid  = 1'b1;
        exc_target = 32'hBFC00400;
        cyc(); // cycle 4 RECOVER, counter 0
        exc_valid = 1'b0;
        n_cmp++;
        if ({flush, stall, epoch} !== 3'b011) begin
            n_fail++;
            $display("FAIL excrec_c4: {flush,stall,epoch} got %b want 011", {flush, stall, epoch});
        end
        cyc(); // cycle 5 HOLD
        n_cmp++;
        if ({flush, stall, busy} !== 3'b011) begin
            n_fail++;
            $display("FAIL excrec_hold: {flush,stall,busy} got %b want 011", {flush, stall, busy});
        end
        cyc(); // cycle 6 FLUSH
        n_cmp++;
        if ({flush, redirect_is_branch, redirect_pc} !== {2'b10, 32'hBFC00400}) begin
            n_fail++;
            $display("FAIL excrec_flush: flush=%b br=%b pc=%h want 1 0 bfc00400", flush, redirect_is_branch, redirect_pc);
        end
        cyc(); // cycle 7
        n_cmp++;
        if ({flush, epoch} !== 2'b00) begin
            n_fail++;
            $display("FAIL excrec_epoch: {flush,epoch} got %b want 00", {flush, epoch});
        end
        fetch_ready = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        exc_valid   = 1'b1;
        exc_target  = 32'hBFC00380;
        fetch_ready = 1'b1;
        cyc();
        exc_valid = 1'b0;
        cyc();
        cyc();
        cyc();
        cyc(); // idle, epoch 1
        fetch_ready = 1'b0;
        mis_valid   = 1'b1;
        mis_epoch   = 1'b1;
        mis_target  = 32'h80005000;
        mis_inst_pc = 32'h80004F00;
        cyc(); // HOLD
        mis_valid = 1'b0;
        n_cmp++;
        if ({busy, stall, epoch} !== 3'b111) begin
            n_fail++;
            $display("FAIL rstmid_pre: {busy,stall,epoch} got %b want 111", {busy, stall, epoch});
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({flush, stall, busy, epoch, redirect_is_branch} !== 5'b00000) begin
            n_fail++;
            $display("FAIL rstmid_async: {flush,stall,busy,epoch,br} got %b want 00000",
                     {flush, stall, busy, epoch, redirect_is_branch});
        end
        n_cmp++;
        if ({redirect_pc, redirect_inst_pc} !== 64'h0) begin
            n_fail++;
            $display("FAIL rstmid_addr: got %h want 0", {redirect_pc, redirect_inst_pc});
        end
        cyc();
        rst         = 1'b0;
        fetch_ready = 1'b1;
        cyc();
        cyc();
        n_cmp++;
        if ({flush, busy, stall} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_lost: {flush,busy,stall} got %b want 000", {flush, busy, stall});
        end
        fetch_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_exc_idle();
        test_mis_hold();
        test_priority();
        test_stale_epoch();
        test_exc_recover();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
